alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
Downstream stage of the 4-bit ALU. Captures every result beat the ALU flags with valid_out: pkt_num, carry, zero and alu.
- Buffers results in a small synchronous FIFO.
- Drains them to the consumer over a valid/ready handshake.
- Checks that pkt_num arrives in strict increasing order, modulo 32.
- Flags overflow and sequence gaps with sticky error bits.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, at least 2
DATA_W, 4, ALU result width
PKT_W, 5, packet-number width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  ALU valid_out
in_alu  in  DATA_W  ALU result
in_carry  in  1  ALU carry
in_zero  in  1  ALU zero
in_pkt_num  in  PKT_W  ALU pkt_num
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_alu  out  DATA_W  head result
out_carry  out  1  head carry
out_zero  out  1  head zero
out_pkt_num  out  PKT_W  head packet number
count  out  $clog2(DEPTH)+1  occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a beat was dropped
seq_err  out  1  sticky: pkt_num mismatch seen
exp_pkt_num  out  PKT_W  next expected pkt_num
clr_err  in  1  clears overflow and seq_err

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - count=0, empty=1, full=0, out_valid=0.
  - Output data fields 0, overflow=0, seq_err=0, exp_pkt_num=0.
  - Read and write pointers 0.
- The ALU input side has no backpressure. in_valid is sampled every cycle.
- Push condition: push = in_valid && (!full || pop).
  - A beat arriving while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the beat is dropped, memory is unchanged, and overflow is set next cycle.
- Pop condition: pop = out_valid && out_ready.
- The FIFO is first-word-fall-through.
  - out_valid = !empty.
  - Output fields are driven from the head entry.
  - Output fields are held stable while out_valid && !out_ready.
- Latency: a beat pushed at edge t appears at the outputs after edge t, i.e. in cycle t+1, when the FIFO was empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push and pop on an empty FIFO cannot happen together, because pop requires out_valid.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Sequence checker, a 2-state FSM:
  - SYNC: entered on reset.
    - First beat with pkt_num==exp_pkt_num (0): move to TRACK.
    - First beat with any other pkt_num: set seq_err and move to TRACK.
  - TRACK: each beat is compared with exp_pkt_num; a mismatch sets seq_err.
  - In either state, on every in_valid: exp_pkt_num <= in_pkt_num + 1, modulo 2^PKT_W. This resynchronises after a gap, and 31 wraps to 0.
  - The check runs on every in_valid beat, including dropped beats.
- clr_err clears overflow and seq_err next cycle. A new error event in the same cycle wins, leaving the bit at 1.
- The FSM state and exp_pkt_num are not affected by clr_err.

Optional Feature:
ALU_COLLECT_STATS_EN
- Defined:
  - Adds outputs carry_cnt, zero_cnt and pkt_cnt, each 16 bits.
  - carry_cnt counts accepted beats with carry=1; zero_cnt counts accepted beats with zero=1; pkt_cnt counts accepted beats.
  - Counters saturate at 16'hFFFF and are cleared by reset or clr_err.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package alu_col_pkg:
  - typedef alu_result_t, a packed struct {pkt_num, carry, zero, alu}.
  - typedef seq_state_e {SYNC, TRACK}.
  - Default width constants PKT_W=5 and DATA_W=4.
- Sub-module alu_col_fifo: a generic FWFT sync FIFO parameterised on element type and DEPTH, with count, full and empty.
- The top level holds push/pop qualification, the sequence FSM, the sticky errors and the optional stats.

Test Plan:
- Reset, then push pkt 0..3 with alu=4'hA..4'hD, out_ready=1 → four outputs in order, one cycle after each push. seq_err=0, exp_pkt_num=4, empty=1 at end.
- out_ready=0, push 8 beats (pkt 0..7) → full=1, count=8. 9th beat pkt 8 → overflow=1, count stays 8. Then drain → outputs pkt 0..7 only.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle (pkt 8) → overflow stays 0, count stays 8, pkt 8 emerges last.
- Push pkt 0,1,3,4 → seq_err=1 after pkt 3, exp_pkt_num=5. clr_err pulse → seq_err=0, and pkt 5 does not reassert it.
- Push pkt 30,31,0 after resync (first beat 30 sets seq_err, then clear) → no further seq_err; exp_pkt_num goes 31 → 0 → 1.
- Assert reset mid-drain with count=5 → next cycle count=0, out_valid=0, errors 0. With ALU_COLLECT_STATS_EN, counters are 0 and pkt_cnt increments on subsequent pushes.

Source files
------------

// File: rtl/alu_col_pkg.sv
// Shared types and default widths for the ALU result collector.
// Optional statistics are enabled with the ALU_COLLECT_STATS_EN macro.
package alu_col_pkg;

  localparam int PKT_W  = 5;
  localparam int DATA_W = 4;

  typedef struct packed {
    logic [PKT_W-1:0]  pkt_num;
    logic              carry;
    logic              zero;
    logic [DATA_W-1:0] alu;
  } alu_result_t;

  typedef enum logic {
    SYNC,
    TRACK
  } seq_state_e;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// ALU result stream in, consumer valid/ready stream out.
// slave is the collector; master is whatever drives beats and consumes results.
interface alu_result_collector_if #(
  parameter int DATA_W = 4,
  parameter int PKT_W  = 5
);

  logic              in_valid;
  logic [DATA_W-1:0] in_alu;
  logic              in_carry;
  logic              in_zero;
  logic [PKT_W-1:0]  in_pkt_num;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu;
  logic              out_carry;
  logic              out_zero;
  logic [PKT_W-1:0]  out_pkt_num;

  modport slave (
    input  in_valid, in_alu, in_carry, in_zero, in_pkt_num, out_ready,
    output out_valid, out_alu, out_carry, out_zero, out_pkt_num
  );

  modport master (
    output in_valid, in_alu, in_carry, in_zero, in_pkt_num, out_ready,
    input  out_valid, out_alu, out_carry, out_zero, out_pkt_num
  );

endinterface

// File: rtl/alu_col_fifo.sv
// Generic first-word-fall-through synchronous FIFO. The caller qualifies
// push/pop; rdata reads as zero whenever the FIFO is empty.
module alu_col_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty masks stale contents, and
  // leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign rdata = empty ? T'('0) : mem[rd_ptr];

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU result beats into a FWFT FIFO, checks pkt_num ordering and keeps
// sticky overflow/sequence errors. ALU_COLLECT_STATS_EN adds beat counters.
module alu_result_collector #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = alu_col_pkg::DATA_W,
  parameter int PKT_W  = alu_col_pkg::PKT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_result_collector_if.slave  bus,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   seq_err,
  output logic [PKT_W-1:0]       exp_pkt_num
`ifdef ALU_COLLECT_STATS_EN
  ,
  output logic [15:0]            carry_cnt,
  output logic [15:0]            zero_cnt,
  output logic [15:0]            pkt_cnt
`endif
);

  import alu_col_pkg::*;

  typedef struct packed {
    logic [PKT_W-1:0]  pkt_num;
    logic              carry;
    logic              zero;
    logic [DATA_W-1:0] alu;
  } beat_t;

  beat_t      wr_beat;
  beat_t      head;
  logic       push;
  logic       pop;
  logic       drop;
  logic       seq_hit;
  seq_state_e state_q;
  seq_state_e state_d;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && !push;

  assign wr_beat = '{pkt_num: bus.in_pkt_num, carry: bus.in_carry,
                     zero: bus.in_zero, alu: bus.in_alu};

  alu_col_fifo #(
    .T     (beat_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_beat),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid   = !empty;
  assign bus.out_alu     = head.alu;
  assign bus.out_carry   = head.carry;
  assign bus.out_zero    = head.zero;
  assign bus.out_pkt_num = head.pkt_num;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    seq_hit = 1'b0;
    case (state_q)
      SYNC: begin
        if (bus.in_valid) begin
          seq_hit = (bus.in_pkt_num != exp_pkt_num);
          state_d = TRACK;
        end
      end
      TRACK: seq_hit = bus.in_valid && (bus.in_pkt_num != exp_pkt_num);
      default: state_d = SYNC;
    endcase
  end

  // Expected number follows every observed beat, dropped or not, so a gap is
  // reported once and the checker resynchronises on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_pkt_num <= '0;
      overflow    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      if (bus.in_valid) exp_pkt_num <= bus.in_pkt_num + 1'b1;

      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;

      if (seq_hit)      seq_err <= 1'b1;
      else if (clr_err) seq_err <= 1'b0;
    end
  end

`ifdef ALU_COLLECT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      carry_cnt <= '0;
      zero_cnt  <= '0;
      pkt_cnt   <= '0;
    end else if (push) begin
      pkt_cnt <= sat_inc(pkt_cnt);
      if (bus.in_carry) carry_cnt <= sat_inc(carry_cnt);
      if (bus.in_zero)  zero_cnt  <= sat_inc(zero_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: stimulus pushes expected beats into
// a scoreboard queue, a negedge monitor compares every beat the DUT hands out.
module tb_alu_result_collector;

  import alu_col_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_err;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       seq_err;
  logic [4:0] exp_pkt_num;
`ifdef ALU_COLLECT_STATS_EN
  logic [15:0] carry_cnt;
  logic [15:0] zero_cnt;
  logic [15:0] pkt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_result_t sbq[$];

  alu_result_collector_if #(.DATA_W(4), .PKT_W(5)) bus ();

  alu_result_collector #(
    .DEPTH  (8),
    .DATA_W (4),
    .PKT_W  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clr_err     (clr_err),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .seq_err     (seq_err),
    .exp_pkt_num (exp_pkt_num)
`ifdef ALU_COLLECT_STATS_EN
    ,
    .carry_cnt   (carry_cnt),
    .zero_cnt    (zero_cnt),
    .pkt_cnt     (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] pkt, input logic [3:0] alu,
                      input logic carry, input logic zero, input bit accept);
    bus.in_valid   = 1'b1;
    bus.in_pkt_num = pkt;
    bus.in_alu     = alu;
    bus.in_carry   = carry;
    bus.in_zero    = zero;
    if (accept) sbq.push_back('{pkt_num: pkt, carry: carry, zero: zero, alu: alu});
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr_err       = 1'b0;
    sbq.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.out_valid) break;
      tick();
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_sb_left", sbq.size(), 32'd0);
  endtask

  // Monitor: a beat is consumed at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got pkt %0d, expected no beat", bus.out_pkt_num);
      end else begin
        alu_result_t e;
        alu_result_t a;
        e = sbq.pop_front();
        a = '{pkt_num: bus.out_pkt_num, carry: bus.out_carry,
              zero: bus.out_zero, alu: bus.out_alu};
        check("out_beat", {21'd0, a}, {21'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_alu     = '0;
    bus.in_carry   = 1'b0;
    bus.in_zero    = 1'b0;
    bus.in_pkt_num = '0;
    bus.out_ready  = 1'b0;
    clr_err        = 1'b0;
    reset          = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst_count",     count, 0);
    check("rst_empty",     {31'd0, empty}, 1);
    check("rst_full",      {31'd0, full}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_alu",   bus.out_alu, 0);
    check("rst_out_pkt",   bus.out_pkt_num, 0);
    check("rst_overflow",  {31'd0, overflow}, 0);
    check("rst_seq_err",   {31'd0, seq_err}, 0);
    check("rst_exp_pkt",   exp_pkt_num, 0);

    // In-order stream with a ready consumer, one cycle of latency
    bus.out_ready = 1'b1;
    send(5'd0, 4'hA, 1'b0, 1'b0, 1'b1);
    check("lat_out_valid", {31'd0, bus.out_valid}, 1);
    check("lat_out_alu",   bus.out_alu, 4'hA);
    send(5'd1, 4'hB, 1'b1, 1'b0, 1'b1);
    send(5'd2, 4'hC, 1'b0, 1'b1, 1'b1);
    send(5'd3, 4'hD, 1'b1, 1'b1, 1'b1);
    idle();
    tick();
    check("t1_empty",   {31'd0, empty}, 1);
    check("t1_seq_err", {31'd0, seq_err}, 0);
    check("t1_exp_pkt", exp_pkt_num, 4);

    // Fill to full, drop the ninth beat
    do_reset();
    for (int i = 0; i < 8; i++) send(5'(i), 4'(i + 1), i[0], i[1], 1'b1);
    check("t2_full",       {31'd0, full}, 1);
    check("t2_count_full", count, 8);
    send(5'd8, 4'hF, 1'b1, 1'b1, 1'b0);
    idle();
    check("t2_overflow",   {31'd0, overflow}, 1);
    check("t2_count_kept", count, 8);
    check("t2_seq_err",    {31'd0, seq_err}, 0);
`ifdef ALU_COLLECT_STATS_EN
    check("t2_pkt_cnt",    pkt_cnt, 8);
`endif
    drain();
    pulse_clr();
    check("t2_ovf_cleared", {31'd0, overflow}, 0);

    // Full FIFO with pop and push in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) send(5'(i), 4'(7 - i), 1'b0, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    send(5'd8, 4'h9, 1'b1, 1'b0, 1'b1);
    idle();
    bus.out_ready = 1'b0;
    check("t3_count",    count, 8);
    check("t3_full",     {31'd0, full}, 1);
    check("t3_overflow", {31'd0, overflow}, 0);
    drain();

    // Gap in sequence, then clear
    do_reset();
    bus.out_ready = 1'b1;
    send(5'd0, 4'h1, 1'b0, 1'b0, 1'b1);
    send(5'd1, 4'h2, 1'b0, 1'b0, 1'b1);
    check("t4_no_err_yet", {31'd0, seq_err}, 0);
    send(5'd3, 4'h3, 1'b0, 1'b0, 1'b1);
    check("t4_seq_err",    {31'd0, seq_err}, 1);
    send(5'd4, 4'h4, 1'b0, 1'b0, 1'b1);
    idle();
    check("t4_exp_pkt",    exp_pkt_num, 5);
    pulse_clr();
    check("t4_err_clear",  {31'd0, seq_err}, 0);
    send(5'd5, 4'h5, 1'b0, 1'b0, 1'b1);
    idle();
    tick();
    check("t4_stays_clear", {31'd0, seq_err}, 0);
    drain();

    // First beat out of sync, then wrap 30 -> 31 -> 0
    do_reset();
    bus.out_ready = 1'b1;
    send(5'd30, 4'h6, 1'b0, 1'b0, 1'b1);
    idle();
    check("t5_sync_err", {31'd0, seq_err}, 1);
    check("t5_exp_31",   exp_pkt_num, 31);
    pulse_clr();
    check("t5_cleared",  {31'd0, seq_err}, 0);
    send(5'd31, 4'h7, 1'b1, 1'b0, 1'b1);
    check("t5_exp_0",    exp_pkt_num, 0);
    send(5'd0, 4'h8, 1'b0, 1'b1, 1'b1);
    idle();
    check("t5_exp_1",    exp_pkt_num, 1);
    tick();
    check("t5_no_err",   {31'd0, seq_err}, 0);
    drain();

    // Reset mid-drain with five entries queued and a sticky error pending
    do_reset();
    for (int i = 1; i <= 6; i++) send(5'(i), 4'(i), 1'b1, 1'b0, 1'b1);
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("t6_count5",   count, 5);
    check("t6_pre_err",  {31'd0, seq_err}, 1);
`ifdef ALU_COLLECT_STATS_EN
    check("t6_pre_pkt_cnt", pkt_cnt, 6);
`endif
    do_reset();
    check("t6_count",     count, 0);
    check("t6_out_valid", {31'd0, bus.out_valid}, 0);
    check("t6_overflow",  {31'd0, overflow}, 0);
    check("t6_seq_err",   {31'd0, seq_err}, 0);
    check("t6_exp_pkt",   exp_pkt_num, 0);
`ifdef ALU_COLLECT_STATS_EN
    check("t6_pkt_cnt0",  pkt_cnt, 0);
    check("t6_carry_cnt0", carry_cnt, 0);
`endif
    send(5'd0, 4'h3, 1'b1, 1'b0, 1'b1);
    idle();
    check("t6_count1", count, 1);
`ifdef ALU_COLLECT_STATS_EN
    check("t6_pkt_cnt1",   pkt_cnt, 1);
    check("t6_carry_cnt1", carry_cnt, 1);
    check("t6_zero_cnt0",  zero_cnt, 0);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
